// File: rtl/sodor_state_diff_scanner.sv
// Snapshots two flattened architectural-state vectors on start and compares them
// one WORD_W slice per cycle, reporting equality, first mismatching slice and count.
module sodor_state_diff_scanner #(
    parameter int unsigned STATE_W       = 1088,
    parameter int unsigned WORD_W        = 32,
    parameter bit          STOP_ON_FIRST = 1'b0,
    localparam int unsigned NWORDS       = (STATE_W + WORD_W - 1) / WORD_W,
    localparam int unsigned IDX_W        = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [STATE_W-1:0] state_a,
    input  logic [STATE_W-1:0] state_b,
    output logic               busy,
    output logic               done,
    output logic               equal,
    output logic [IDX_W-1:0]   first_diff_idx,
    output logic [IDX_W:0]     diff_count
);

    localparam int unsigned PAD_W = NWORDS * WORD_W;
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PAD_W-1:0] shadow_a_q, shadow_a_d;
    logic [PAD_W-1:0] shadow_b_q, shadow_b_d;
    logic             equal_q, equal_d;
    logic [IDX_W-1:0] first_diff_q, first_diff_d;
    logic [CNT_W-1:0] diff_count_q, diff_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             word_diff;

    // Shadows shift down one slice per SCAN cycle, so the slice under test is always the low word.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_a_d   = shadow_a_q;
        shadow_b_d   = shadow_b_q;
        equal_d      = equal_q;
        first_diff_d = first_diff_q;
        diff_count_d = diff_count_q;
        word_diff    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_a_d   = PAD_W'(state_a);
                    shadow_b_d   = PAD_W'(state_b);
                    idx_d        = '0;
                    diff_count_d = '0;
                    first_diff_d = '1;
                    equal_d      = 1'b1;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                word_diff  = (shadow_a_q[WORD_W-1:0] != shadow_b_q[WORD_W-1:0]);
                shadow_a_d = shadow_a_q >> WORD_W;
                shadow_b_d = shadow_b_q >> WORD_W;
                if (word_diff) begin
                    diff_count_d = diff_count_q + CNT_W'(1);
                    equal_d      = 1'b0;
                    if (equal_q) begin
                        first_diff_d = idx_q;
                    end
                end
                if ((idx_q == IDX_W'(NWORDS - 1)) || (word_diff && STOP_ON_FIRST)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            shadow_a_q   <= '0;
            shadow_b_q   <= '0;
            equal_q      <= 1'b1;
            first_diff_q <= '1;
            diff_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_a_q   <= shadow_a_d;
            shadow_b_q   <= shadow_b_d;
            equal_q      <= equal_d;
            first_diff_q <= first_diff_d;
            diff_count_q <= diff_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign equal          = equal_q;
    assign first_diff_idx = first_diff_q;
    assign diff_count     = diff_count_q;

endmodule
